// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - command opcodes, response codes and link timing defaults
package cmd_pkg;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] SET_CAL   = 8'h06;
  localparam logic [7:0] SET_EMGL  = 8'h07;
  localparam logic [7:0] SET_MOFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;

  // 50 MHz / 19200 baud, and 20 ms of inter-byte silence
  localparam int DEF_BAUD_DIV = 2604;
  localparam int DEF_TMO_CLKS = 1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } frm_state_t;

endpackage

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - bit-level UART receive and transmit engines, 8N1
module uart_xcvr
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic TX_IDLE = 1'b0;
  localparam logic TX_XMIT = 1'b1;

  logic          rx_ff1, rx_ff2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  logic          tx_state;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_q;

  assign rx_data = rx_shift;
  assign tx      = tx_q;
  assign tx_done = (tx_state == TX_XMIT) && (tx_cnt == BIT_END) && (tx_bit == 4'd9);

  // Synchroniser and edge history preset high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1   <= 1'b1;
      rx_ff2   <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_ff1  <= rx;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_ff2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_state <= rx_ff2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_ff2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_ff2) rx_rdy  <= 1'b1;
            else        frm_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Stop bit rides in the top of the shift register so it falls out after the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_q     <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift <= {1'b1, tx_data};
            tx_q     <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_XMIT;
          end
        end
        default: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              tx_q     <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_q     <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// rtl/cmd_uart_wrapper.sv - 3-byte command frame receiver and 1-byte response sender
module cmd_uart_wrapper
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int TMO_CLKS = DEF_TMO_CLKS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int TW = $clog2(TMO_CLKS + 1);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_CLKS - 1);

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_done;

  frm_state_t    frm_state;
  logic [7:0]    cmd_shdw;
  logic [7:0]    hi_shdw;
  logic [TW-1:0] tmo_cnt;
  logic          frm_done;
  logic          frm_first;

  uart_xcvr #(
    .BAUD_DIV(BAUD_DIV)
  ) u_xcvr (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (RX),
    .tx     (TX),
    .rx_rdy (rx_rdy),
    .rx_data(rx_data),
    .frm_err(frm_err),
    .trmt   (send_resp),
    .tx_data(resp),
    .tx_done(tx_done)
  );

  assign frm_done  = rx_rdy && (frm_state == LOW);
  assign frm_first = rx_rdy && (frm_state == IDLE);

  // Bytes land in shadows; cmd/data only move when the third byte arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_state <= IDLE;
      cmd_shdw  <= '0;
      hi_shdw   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      data      <= '0;
    end else if (frm_err) begin
      frm_state <= IDLE;
      tmo_cnt   <= '0;
    end else if (rx_rdy) begin
      tmo_cnt <= '0;
      case (frm_state)
        IDLE: begin
          cmd_shdw  <= rx_data;
          frm_state <= HIGH;
        end
        HIGH: begin
          hi_shdw   <= rx_data;
          frm_state <= LOW;
        end
        LOW: begin
          cmd       <= cmd_shdw;
          data      <= {hi_shdw, rx_data};
          frm_state <= IDLE;
        end
        default: frm_state <= IDLE;
      endcase
    end else if (frm_state != IDLE) begin
      if (tmo_cnt == TMO_END) begin
        frm_state <= IDLE;
        cmd_shdw  <= '0;
        hi_shdw   <= '0;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cmd_rdy <= 1'b0;
    else if (frm_done)                 cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy || frm_first) cmd_rdy <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         resp_sent <= 1'b0;
    else if (tx_done)   resp_sent <= 1'b1;
    else if (send_resp) resp_sent <= 1'b0;
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb/tb_cmd_uart_wrapper.sv - host-side stimulus and frame-level reference checks
module tb_cmd_uart_wrapper;
  import cmd_pkg::*;

  localparam int B   = 32;
  localparam int TMO = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        frm_err;

  int n_checks = 0;
  int n_pass   = 0;
  int frm_err_cnt = 0;

  logic [7:0]  exp_cmd  = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_rdy  = 1'b0;

  cmd_uart_wrapper #(
    .BAUD_DIV(B),
    .TMO_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .data       (data),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent),
    .frm_err    (frm_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frm_err === 1'b1) frm_err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic gap(input int lo, input int hi);
    repeat ($urandom_range(lo, hi)) @(negedge clk);
  endtask

  // Host transmitter: start, 8 data LSB first, stop; optional look before the stop midpoint
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit early);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      if (i == 9 && early) begin
        repeat (B / 4) @(negedge clk);
        check("rdy_before_stop", cmd_rdy, 0);
        check("cmd_before_stop", cmd, exp_cmd);
        check("data_before_stop", data, exp_data);
        repeat (B - B / 4) @(negedge clk);
      end else begin
        repeat (B) @(negedge clk);
      end
    end
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input bit early);
    send_byte(c, 1'b1, 1'b0);
    exp_rdy = 1'b0;
    gap(1, 20);
    send_byte(hi, 1'b1, 1'b0);
    check("partial_rdy", cmd_rdy, exp_rdy);
    check("partial_cmd", cmd, exp_cmd);
    check("partial_data", data, exp_data);
    gap(1, 20);
    send_byte(lo, 1'b1, early);
    exp_cmd  = c;
    exp_data = {hi, lo};
    exp_rdy  = 1'b1;
    repeat (2) @(negedge clk);
    check("frame_rdy", cmd_rdy, exp_rdy);
    check("frame_cmd", cmd, exp_cmd);
    check("frame_data", data, exp_data);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    @(negedge clk);
    check("after_clr", cmd_rdy, exp_rdy);
  endtask

  task automatic start_resp(input logic [7:0] b);
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp = ~b;
  endtask

  // Expects an exact 10*B frame; optionally fires a second send_resp mid-byte
  task automatic check_tx(input logic [7:0] b, input bit intr);
    logic [9:0] fb;
    int w;
    fb = {1'b1, b, 1'b0};
    start_resp(b);
    w = 0;
    while (TX !== 1'b0 && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_bit", TX, 0);
    for (int n = 0; n <= 10 * B; n++) begin
      if (n < 10 * B && (n % B == 1 || n % B == B - 1)) check("tx_bit", TX, fb[n / B]);
      if (n == 5 * B)      check("resp_sent_mid", resp_sent, 0);
      if (n == 10 * B - 1) check("resp_sent_early", resp_sent, 0);
      if (n == 10 * B)     check("resp_sent_done", resp_sent, 1);
      if (intr && n == 4 * B + 3) begin
        resp = 8'h3C;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
      if (n < 10 * B) @(negedge clk);
    end
    repeat (2 * B) @(negedge clk);
    check("tx_idle_after", TX, 1);
    check("resp_sent_hold", resp_sent, 1);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, hi, lo;
    int err_base;

    @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd", cmd, 0);
    check("rst_data", data, 0);
    check("rst_rdy", cmd_rdy, 0);
    check("rst_resp_sent", resp_sent, 0);
    check("rst_frm_err", frm_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(SET_THRST, 8'h00, 8'hFF, 1'b1);

    send_frame(SET_ROLL, 8'hFF, 8'h80, 1'b0);
    pulse_clr();
    send_frame(SET_PTCH, 8'h01, 8'h00, 1'b0);

    send_byte(SET_YAW, 1'b1, 1'b0);
    exp_rdy = 1'b0;
    gap(1, 5);
    send_byte(8'h00, 1'b1, 1'b0);
    repeat (TMO + TMO / 5) @(negedge clk);
    check("tmo_rdy", cmd_rdy, 0);
    check("tmo_cmd", cmd, exp_cmd);
    send_frame(SET_CAL, 8'h12, 8'h34, 1'b0);

    err_base = frm_err_cnt;
    send_byte(8'h01, 1'b1, 1'b0);
    exp_rdy = 1'b0;
    gap(1, 5);
    send_byte(8'h5A, 1'b0, 1'b0);
    repeat (B) @(negedge clk);
    check("frm_err_pulse", frm_err_cnt - err_base, 1);
    check("frm_err_no_rdy", cmd_rdy, 0);
    send_frame(SET_MOFF, 8'h00, 8'h00, 1'b0);

    check_tx(POS_ACK, 1'b1);

    for (int r = 0; r < 6; r++) begin
      c  = 8'($urandom_range(2, 8));
      hi = 8'($urandom);
      lo = 8'($urandom);
      send_frame(c, hi, lo, 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      gap(1, 40);
    end

    for (int r = 0; r < 2; r++) check_tx(8'($urandom), 1'b0);

    c  = 8'($urandom_range(2, 8));
    hi = 8'($urandom);
    lo = 8'($urandom);
    fork
      send_frame(c, hi, lo, 1'b0);
      check_tx(8'($urandom), 1'b0);
    join
    check("frm_err_total", frm_err_cnt - err_base, 1);

    start_resp(8'h00);
    repeat (3 * B) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_tx_abort", TX, 1);
    check("rst_resp_sent_abort", resp_sent, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = 8'h00;
    exp_data = 16'h0000;
    exp_rdy = 1'b0;
    repeat (12 * B) @(negedge clk);
    check("tx_no_resume", TX, 1);
    check("resp_sent_no_resume", resp_sent, 0);

    send_byte(SET_EMGL, 1'b1, 1'b0);
    gap(1, 5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", cmd_rdy, 0);
    check("rst_mid_tx", TX, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("post_rst_cmd", cmd, 0);
    check("post_rst_data", data, 0);
    check("post_rst_rdy", cmd_rdy, 0);
    send_frame(SET_THRST, 8'hAB, 8'hCD, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
